mc_ctrl: RTL and testbench

//  Multicycle sequencer for the MIPS datapath (pc, im_4k, gpr, alu, dm_4k, ext, npc, muxes).

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_if.sv | 31 +++
 rtl/mc_ctrl_decode.sv | 25 ++
 rtl/mc_ctrl.sv | 107 ++++++++++
 tb/tb_mc_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state codes, opcode/funct constants, select encodings and decode class
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DCD = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_PASSB = 4'd4;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_31 = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_PCP4 = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    typedef struct packed {
        logic addu;
        logic subu;
        logic slt;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction fields and flags in, strobes and datapath selects out
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic             stall;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             PCWr;
    logic             IRWr;
    logic             RegWrite;
    logic             MemWrite;
    logic [2:0]       NpcSel;
    logic [1:0]       RegDst;
    logic [1:0]       wd_sel;
    logic [1:0]       ExtOp;
    logic             AluSrc;
    logic [3:0]       AluCtrl;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  stall, opcode, funct, zero,
        output PCWr, IRWr, RegWrite, MemWrite, NpcSel, RegDst, wd_sel,
               ExtOp, AluSrc, AluCtrl, illegal, retired
    );

    modport slave (
        output stall, opcode, funct, zero,
        input  PCWr, IRWr, RegWrite, MemWrite, NpcSel, RegDst, wd_sel,
               ExtOp, AluSrc, AluCtrl, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: opcode/funct to one-hot instruction class plus illegal flag
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output cls_t       o_cls,
    output logic       o_illegal
);
    logic w_r;

    assign w_r         = i_opcode == OP_R;
    assign o_cls.addu  = w_r && i_funct == FN_ADDU;
    assign o_cls.subu  = w_r && i_funct == FN_SUBU;
    assign o_cls.slt   = w_r && i_funct == FN_SLT;
    assign o_cls.jr    = w_r && i_funct == FN_JR;
    assign o_cls.ori   = i_opcode == OP_ORI;
    assign o_cls.lui   = i_opcode == OP_LUI;
    assign o_cls.lw    = i_opcode == OP_LW;
    assign o_cls.sw    = i_opcode == OP_SW;
    assign o_cls.beq   = i_opcode == OP_BEQ;
    assign o_cls.j     = i_opcode == OP_J;
    assign o_cls.jal   = i_opcode == OP_JAL;
    assign o_illegal   = o_cls == '0;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS sequencer with stall, illegal detect and retired counter
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    cls_t             w_cls;
    logic             w_ill;
    logic             w_go;
    logic             w_jmp;
    logic             w_rtype;
    logic             w_act;
    logic             w_done;
    logic             w_pc;
    logic             w_ir;
    logic             w_rw;
    logic             w_mw;
    logic             w_il;

    mc_ctrl_decode u_decode (
        .i_opcode  (bus.opcode),
        .i_funct   (bus.funct),
        .o_cls     (w_cls),
        .o_illegal (w_ill)
    );

    assign w_go    = rst && !bus.stall;
    assign w_jmp   = w_cls.j || w_cls.jal || w_cls.jr;
    assign w_rtype = w_cls.addu || w_cls.subu || w_cls.slt;
    assign w_act   = r_state inside {S_DCD, S_EXE, S_MEM, S_WB};

    // state register and retired counter; stall freezes both
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IF;
            r_retired <= '0;
        end else if (!bus.stall) begin
            r_state <= w_next;
            if (w_done)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // next state, raw strobes and the retire event of the final state
    always_comb begin
        w_next = S_IF;
        w_pc   = 1'b0;
        w_ir   = 1'b0;
        w_rw   = 1'b0;
        w_mw   = 1'b0;
        w_il   = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IF: begin
                w_ir   = 1'b1;
                w_pc   = 1'b1;
                w_next = S_DCD;
            end
            S_DCD: begin
                w_pc   = w_jmp;
                w_rw   = w_cls.jal;
                w_il   = w_ill;
                w_done = w_jmp;
                w_next = (w_jmp || w_ill) ? S_IF : S_EXE;
            end
            S_EXE: begin
                w_pc   = w_cls.beq && bus.zero;
                w_done = w_cls.beq;
                w_next = w_cls.beq ? S_IF : (w_cls.lw || w_cls.sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_mw   = w_cls.sw;
                w_done = w_cls.sw;
                w_next = w_cls.sw ? S_IF : S_WB;
            end
            S_WB: begin
                w_rw   = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // strobes die during reset or stall; selects depend only on state and decode so they hold steady
    assign bus.PCWr     = w_pc && w_go;
    assign bus.IRWr     = w_ir && w_go;
    assign bus.RegWrite = w_rw && w_go;
    assign bus.MemWrite = w_mw && w_go;
    assign bus.illegal  = w_il && w_go;
    assign bus.retired  = r_retired;
    assign bus.NpcSel   = !w_act ? NPC_PC4 : w_cls.jr ? NPC_JR :
                          (w_cls.j || w_cls.jal) ? NPC_J : w_cls.beq ? NPC_BEQ : NPC_PC4;
    assign bus.RegDst   = !w_act ? RD_RT : w_cls.jal ? RD_31 : w_rtype ? RD_RD : RD_RT;
    assign bus.wd_sel   = !w_act ? WD_ALU : w_cls.jal ? WD_PCP4 : w_cls.lw ? WD_MEM : WD_ALU;
    assign bus.ExtOp    = !w_act ? EXT_ZERO : w_cls.lui ? EXT_LUI :
                          (w_cls.lw || w_cls.sw) ? EXT_SIGN : EXT_ZERO;
    assign bus.AluSrc   = w_act && (w_cls.ori || w_cls.lui || w_cls.lw || w_cls.sw);
    assign bus.AluCtrl  = !w_act ? ALU_ADD : (w_cls.subu || w_cls.beq) ? ALU_SUB :
                          w_cls.slt ? ALU_SLT : w_cls.ori ? ALU_OR : w_cls.lui ? ALU_PASSB : ALU_ADD;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-instruction walks of mc_ctrl with hand-computed state/strobe/select sequences
module tb_mc_ctrl;
    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    logic [31:0] exp_ret;
    logic [2:0]  obs_st  [8];
    logic [4:0]  obs_sb  [8];
    logic [13:0] obs_sel [8];
    logic [31:0] obs_ret [8];

    mc_ctrl_if #(.CNT_W(32)) bus ();

    mc_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one instruction for n cycles, recording outputs 1 ns after inputs settle
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [7:0] stl, input int n);
        for (int i = 0; i < n; i++) begin
            bus.opcode = op;
            bus.funct  = fn;
            bus.zero   = z;
            bus.stall  = stl[i];
            #1;
            obs_st[i]  = dut.r_state;
            obs_sb[i]  = {bus.PCWr, bus.IRWr, bus.RegWrite, bus.MemWrite, bus.illegal};
            obs_sel[i] = {bus.NpcSel, bus.RegDst, bus.wd_sel, bus.ExtOp, bus.AluSrc, bus.AluCtrl};
            obs_ret[i] = bus.retired;
            @(posedge clk);
            #2;
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.opcode = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (dut.r_state !== 3'd0 || bus.PCWr !== 1'b0 || bus.IRWr !== 1'b0 || bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL reset st=%0d pcwr=%b irwr=%b ret=%0d exp st=0 pcwr=0 irwr=0 ret=0",
                     dut.r_state, bus.PCWr, bus.IRWr, bus.retired);
        end
        rst = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_addu();
        logic [11:0] es;
        logic [19:0] eb;
        es = {3'd0, 3'd1, 3'd2, 3'd4};
        eb = {5'b11000, 5'b00000, 5'b00000, 5'b00100};
        run(6'b000000, 6'b100001, 1'b0, 8'h00, 4);
        exp_ret++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_st[i] !== es[3*(3-i) +: 3] || obs_sb[i] !== eb[5*(3-i) +: 5]) begin
                errors++;
                $display("FAIL addu cyc%0d st=%0d sb=%b exp st=%0d sb=%b",
                         i, obs_st[i], obs_sb[i], es[3*(3-i) +: 3], eb[5*(3-i) +: 5]);
            end
        end
        checks++;
        if (obs_sel[2][4:0] !== 5'b00000 || obs_sel[3][10:9] !== 2'd1 || obs_sel[3][8:7] !== 2'd0 || obs_sel[3][4:0] !== 5'b00000) begin
            errors++;
            $display("FAIL addu_sel exe=%h wb=%h exp src0 ADD, RegDst1 wd0", obs_sel[2], obs_sel[3]);
        end
        checks++;
        if (bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL addu_ret got %0d exp %0d", bus.retired, exp_ret);
        end
    endtask

    task automatic test_sw_lw();
        logic [14:0] es;
        logic [24:0] eb;
        es = {3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        eb = {5'b11000, 5'b00000, 5'b00000, 5'b00010, 5'b11000};
        run(6'b101011, 6'b000000, 1'b0, 8'h00, 4);
        exp_ret++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_st[i] !== es[3*(4-i) +: 3] || obs_sb[i] !== eb[5*(4-i) +: 5]) begin
                errors++;
                $display("FAIL sw cyc%0d st=%0d sb=%b exp st=%0d sb=%b",
                         i, obs_st[i], obs_sb[i], es[3*(4-i) +: 3], eb[5*(4-i) +: 5]);
            end
        end
        es = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        eb = {5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
        run(6'b100011, 6'b000100, 1'b0, 8'h00, 5);
        exp_ret++;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_st[i] !== es[3*(4-i) +: 3] || obs_sb[i] !== eb[5*(4-i) +: 5]) begin
                errors++;
                $display("FAIL lw cyc%0d st=%0d sb=%b exp st=%0d sb=%b",
                         i, obs_st[i], obs_sb[i], es[3*(4-i) +: 3], eb[5*(4-i) +: 5]);
            end
        end
        for (int i = 2; i < 5; i++) begin
            checks++;
            if (obs_sel[i][6:0] !== 7'b01_1_0000) begin
                errors++;
                $display("FAIL lw_sel cyc%0d ext/src/alu=%b exp 0110000", i, obs_sel[i][6:0]);
            end
        end
        checks++;
        if (obs_sel[4][10:7] !== 4'b0001 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL lw_wb regdst/wd=%b ret=%0d exp 0001 ret=%0d", obs_sel[4][10:7], bus.retired, exp_ret);
        end
    endtask

    task automatic test_beq();
        for (int t = 0; t < 2; t++) begin
            run(6'b000100, 6'b000000, t == 0, 8'h00, 3);
            exp_ret++;
            checks++;
            if (obs_st[2] !== 3'd2 || obs_sb[2] !== {t == 0, 4'b0000} || obs_sb[1] !== 5'b0
                || obs_sel[2][13:11] !== 3'd1 || obs_sel[2][4:0] !== 5'b00001) begin
                errors++;
                $display("FAIL beq taken=%0d st=%0d sb=%b npc=%0d alu=%b exp st=2 pcwr=%0d npc=1 alu=00001",
                         t == 0, obs_st[2], obs_sb[2], obs_sel[2][13:11], obs_sel[2][4:0], t == 0);
            end
            checks++;
            if (dut.r_state !== 3'd0 || bus.retired !== exp_ret) begin
                errors++;
                $display("FAIL beq_end st=%0d ret=%0d exp st=0 ret=%0d", dut.r_state, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_jal_jr();
        run(6'b000011, 6'b000000, 1'b0, 8'h00, 2);
        exp_ret++;
        checks++;
        if (obs_st[1] !== 3'd1 || obs_sb[1] !== 5'b10100 || obs_sel[1][13:7] !== 7'b010_10_10) begin
            errors++;
            $display("FAIL jal sb=%b sel=%b exp sb=10100 npc/rd/wd=0101010", obs_sb[1], obs_sel[1][13:7]);
        end
        run(6'b000000, 6'b001000, 1'b0, 8'h00, 2);
        exp_ret++;
        checks++;
        if (obs_st[1] !== 3'd1 || obs_sb[1] !== 5'b10000 || obs_sel[1][13:11] !== 3'd3) begin
            errors++;
            $display("FAIL jr sb=%b npc=%0d exp sb=10000 npc=3", obs_sb[1], obs_sel[1][13:11]);
        end
        checks++;
        if (dut.r_state !== 3'd0 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL jr_end st=%0d ret=%0d exp st=0 ret=%0d", dut.r_state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        ops[0] = 6'b111111;
        ops[1] = 6'b000000;
        for (int t = 0; t < 2; t++) begin
            run(ops[t], 6'b000000, 1'b0, 8'h00, 2);
            checks++;
            if (obs_st[1] !== 3'd1 || obs_sb[1] !== 5'b00001 || dut.r_state !== 3'd0 || bus.retired !== exp_ret) begin
                errors++;
                $display("FAIL illegal op=%b sb=%b st_after=%0d ret=%0d exp sb=00001 st=0 ret=%0d",
                         ops[t], obs_sb[1], dut.r_state, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_stall();
        logic [20:0] es;
        logic [34:0] eb;
        es = {3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        eb = {5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010};
        run(6'b101011, 6'b000000, 1'b0, 8'b0011_1000, 7);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs_st[i] !== es[3*(6-i) +: 3] || obs_sb[i] !== eb[5*(6-i) +: 5]) begin
                errors++;
                $display("FAIL stall cyc%0d st=%0d sb=%b exp st=%0d sb=%b",
                         i, obs_st[i], obs_sb[i], es[3*(6-i) +: 3], eb[5*(6-i) +: 5]);
            end
        end
        checks++;
        if (obs_ret[5] !== exp_ret || obs_sel[4][6:0] !== 7'b01_1_0000) begin
            errors++;
            $display("FAIL stall_hold ret=%0d sel=%b exp ret=%0d sel=0110000", obs_ret[5], obs_sel[4][6:0], exp_ret);
        end
        exp_ret++;
        checks++;
        if (dut.r_state !== 3'd0 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL stall_end st=%0d ret=%0d exp st=0 ret=%0d", dut.r_state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0] ops [4];
        logic [5:0] fns [4];
        logic [6:0] esel [4];
        logic [1:0] erd [4];
        ops[0] = 6'b000000; fns[0] = 6'b100011; esel[0] = 7'b00_0_0001; erd[0] = 2'd1;
        ops[1] = 6'b000000; fns[1] = 6'b101010; esel[1] = 7'b00_0_0011; erd[1] = 2'd1;
        ops[2] = 6'b001101; fns[2] = 6'b000000; esel[2] = 7'b00_1_0010; erd[2] = 2'd0;
        ops[3] = 6'b001111; fns[3] = 6'b000000; esel[3] = 7'b10_1_0100; erd[3] = 2'd0;
        for (int t = 0; t < 4; t++) begin
            run(ops[t], fns[t], 1'b0, 8'h00, 4);
            exp_ret++;
            checks++;
            if (obs_st[3] !== 3'd4 || obs_sb[3] !== 5'b00100 || obs_sel[2][6:0] !== esel[t]
                || obs_sel[3][6:0] !== esel[t] || obs_sel[3][10:9] !== erd[t] || bus.retired !== exp_ret) begin
                errors++;
                $display("FAIL alu_op%0d st=%0d sb=%b exe=%b wb=%b rd=%0d ret=%0d exp st=4 sb=00100 sel=%b rd=%0d ret=%0d",
                         t, obs_st[3], obs_sb[3], obs_sel[2][6:0], obs_sel[3][6:0], obs_sel[3][10:9],
                         bus.retired, esel[t], erd[t], exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid();
        run(6'b000000, 6'b100001, 1'b0, 8'h00, 2);
        rst = 1'b0;
        exp_ret = 0;
        #1;
        checks++;
        if (dut.r_state !== 3'd0 || bus.PCWr !== 1'b0 || bus.IRWr !== 1'b0 || bus.RegWrite !== 1'b0
            || bus.MemWrite !== 1'b0 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL reset_mid st=%0d strobes=%b%b%b%b ret=%0d exp st=0 strobes=0000 ret=0",
                     dut.r_state, bus.PCWr, bus.IRWr, bus.RegWrite, bus.MemWrite, bus.retired);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.r_state !== 3'd0 || bus.IRWr !== 1'b1 || bus.PCWr !== 1'b1) begin
            errors++;
            $display("FAIL reset_rel st=%0d irwr=%b pcwr=%b exp st=0 irwr=1 pcwr=1", dut.r_state, bus.IRWr, bus.PCWr);
        end
        @(posedge clk);
        #2;
        checks++;
        if (dut.r_state !== 3'd1 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL reset_edge st=%0d ret=%0d exp st=1 ret=0", dut.r_state, bus.retired);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_addu();
        test_sw_lw();
        test_beq();
        test_jal_jr();
        test_illegal();
        test_stall();
        test_alu_ops();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
